imem_responder: RTL
===================

Name: imem_responder

Overview:
Instruction-memory responder for the pipelined RV32I core. It sits at the far end of the fetch interface: it takes the fetch PC produced by the control unit and returns the instruction word.
- A byte-serial program loader fills the memory after reset. The block then switches to RUN and serves one fetch per cycle with registered read data.
- Out-of-range and misaligned fetches return a NOP and raise a fault flag.

Parameters:
DEPTH_WORDS, 256, number of 32-bit instruction words (power of two, >=4)
NOP_INST, 32'h00000013, word returned on reset, during LOAD, and on faulting fetches (addi x0,x0,0)

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous active-low reset
pc  input  32  fetch byte address from the control unit
inst  output  32  fetched instruction, registered
inst_valid  output  1  inst corresponds to the pc sampled on the previous edge in RUN
fetch_fault  output  1  registered alongside inst; previous pc was misaligned or out of range
ld_valid  input  1  loader byte valid
ld_ready  output  1  block accepts a loader byte this cycle
ld_byte  input  8  program byte, little-endian stream
ld_last  input  1  qualifies ld_byte as the final byte of the program
ld_done  output  1  high while in RUN

Behaviour:
- Reset (rst=0, asynchronous) puts the block in the following state:
  - state=LOAD; wptr=0; byte count bcnt=0; assembly register=0.
  - inst=NOP_INST; inst_valid=0; fetch_fault=0; ld_done=0.
  - Memory contents are not cleared.
- States are LOAD and RUN. A transfer is a cycle with ld_valid & ld_ready.
- LOAD behaviour:
  - ld_ready=1 while wptr<DEPTH_WORDS.
  - Each transfer places ld_byte into lane bcnt (lane 0 = bits 7:0); bcnt increments mod 4.
  - When bcnt==3, or when ld_last is set, the assembled word is written to mem[wptr] on that edge. Unfilled upper lanes are zero. Then wptr++ and bcnt resets to 0.
  - Transfer with ld_last: state becomes RUN on the same edge.
  - A write into the last slot (wptr==DEPTH_WORDS-1) also forces RUN on the same edge, even without ld_last. Further bytes are never accepted; ld_ready drops with the transition.
  - ld_valid without ld_ready: no effect; the loader holds the byte.
  - In LOAD, inst=NOP_INST and inst_valid=0 every cycle.
- RUN behaviour:
  - ld_ready=0 and ld_done=1.
  - Every edge samples pc; inst, inst_valid and fetch_fault update one cycle later (latency 1, throughput 1 per cycle, no stalls).
  - The word index is pc[31:2]. Fault when pc[1:0]!=0 or index>=DEPTH_WORDS. A fault sets inst=NOP_INST and fetch_fault=1, with inst_valid=1.
  - Otherwise inst=mem[index] and fetch_fault=0.
- Slots that were never loaded return their stale or undefined contents; no fault is raised for them.
- Reset mid-LOAD or mid-RUN discards the partial word and returns to LOAD at wptr=0.
- The first RUN fetch result appears on the second edge after the ld_last transfer.

Optional Feature:
IMEM_RELOAD_EN.
- Defined:
  - In RUN, ld_ready=1.
  - The first transfer in RUN returns state to LOAD with wptr=0, and that byte is stored as lane 0 of word 0.
  - The inst output falls back to NOP_INST with inst_valid=0 from the next edge.
  - If that byte carries ld_last, it is written as word 0 and the block stays in RUN.
- Undefined: ld_ready=0 in RUN; only reset re-enters LOAD.

Decomposition:
- Package imem_pkg holds:
  - state enum (LOAD, RUN);
  - NOP_INST constant;
  - localparam function for the index width, clog2(DEPTH_WORDS).
- One natural sub-module, imem_byte_packer, owns:
  - the lane counter and assembly register;
  - word-complete and ld_last handling.
  It emits a one-cycle wr_en with wr_data.

Test Plan:
- Reset, stream bytes 13 00 00 00 93 00 50 00 with ld_last on the final byte, then pc=0 and pc=4 → inst=00000013 and then 00500093; inst_valid=1; fetch_fault=0; ld_done=1.
- Stream 3 bytes AA BB CC with ld_last on CC, then pc=0 → inst=00CCBBAA.
- In RUN, pc=2 → inst=00000013 with fetch_fault=1. With DEPTH_WORDS=256, pc=0x400 → NOP with fetch_fault=1.
- Load 4*DEPTH_WORDS bytes without ld_last → ld_ready falls the cycle after the last byte and ld_done=1; the final word is readable at pc=4*(DEPTH_WORDS-1).
- Assert rst low mid-word (after 2 bytes), release, load 4 fresh bytes → word 0 equals the fresh bytes; inst=NOP_INST and inst_valid=0 throughout the reload.
- With IMEM_RELOAD_EN, in RUN send byte 11 with ld_valid → inst_valid=0 next cycle; after 3 more bytes with ld_last, pc=0 → inst=xxxxxx11 in the expected lane order.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Holds the LOAD/RUN state encoding, the default NOP word and the index-width helper.
package imem_pkg;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  function automatic int unsigned idx_w(input int unsigned depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Packs the little-endian loader byte stream into 32-bit words; emits a one-cycle wr_en.
// wr_data is combinational on the completing transfer; no backpressure of its own.
module imem_byte_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        xfer,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  output logic        wr_en,
  output logic [31:0] wr_data
);

  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] asm_q, asm_d;

  always_comb begin
    // asm_q only ever holds lanes below bcnt, so the upper lanes are already zero
    wr_data = asm_q;
    wr_data[{bcnt_q, 3'b000} +: 8] = ld_byte;
    wr_en  = xfer && ((bcnt_q == 2'd3) || ld_last);
    bcnt_d = bcnt_q;
    asm_d  = asm_q;
    if (wr_en) begin
      bcnt_d = 2'd0;
      asm_d  = 32'd0;
    end else if (xfer) begin
      bcnt_d = bcnt_q + 2'd1;
      asm_d  = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt_q <= 2'd0;
      asm_q  <= 32'd0;
    end else begin
      bcnt_q <= bcnt_d;
      asm_q  <= asm_d;
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction memory: byte-serial LOAD, then one registered fetch per cycle in RUN (latency 1, no stalls).
// Define IMEM_RELOAD_EN to let a loader byte in RUN restart LOAD at word 0.
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] NOP_INST    = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        fetch_fault,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  output logic        ld_done
);

  localparam int unsigned IW        = idx_w(DEPTH_WORDS);
  localparam logic [IW:0] WPTR_LAST = (IW + 1)'(DEPTH_WORDS - 1);

  state_t        state_q, state_d;
  logic [IW:0]   wptr_q, wptr_d;
  logic [31:0]   inst_q, inst_d;
  logic          inst_valid_q, inst_valid_d;
  logic          fetch_fault_q, fetch_fault_d;
  logic          xfer;
  logic          wr_en;
  logic [31:0]   wr_data;
  logic [IW-1:0] wr_addr;
  logic [31:0]   mem_q [DEPTH_WORDS];

  always_comb begin
    ld_ready = (state_q == ST_LOAD) && !wptr_q[IW];
`ifdef IMEM_RELOAD_EN
    if (state_q == ST_RUN) ld_ready = 1'b1;
`endif
    xfer = ld_valid && ld_ready;
  end

  imem_byte_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .xfer    (xfer),
    .ld_byte (ld_byte),
    .ld_last (ld_last),
    .wr_en   (wr_en),
    .wr_data (wr_data)
  );

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    wr_addr = wptr_q[IW-1:0];
    case (state_q)
      ST_LOAD: begin
        if (wr_en) begin
          wptr_d = wptr_q + {{IW{1'b0}}, 1'b1};
          if (ld_last || (wptr_q == WPTR_LAST)) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Only reachable with reload: the byte restarts at word 0, lane 0
        if (xfer) begin
          wr_addr = '0;
          wptr_d  = {{IW{1'b0}}, wr_en};
          state_d = ld_last ? ST_RUN : ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    inst_d        = NOP_INST;
    inst_valid_d  = 1'b0;
    fetch_fault_d = 1'b0;
    if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
      inst_valid_d = 1'b1;
      if ((pc[1:0] != 2'b00) || ({2'b00, pc[31:2]} >= 32'(DEPTH_WORDS))) begin
        fetch_fault_d = 1'b1;
      end else begin
        inst_d = mem_q[pc[IW+1:2]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_LOAD;
      wptr_q        <= '0;
      inst_q        <= NOP_INST;
      inst_valid_q  <= 1'b0;
      fetch_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      inst_q        <= inst_d;
      inst_valid_q  <= inst_valid_d;
      fetch_fault_q <= fetch_fault_d;
    end
  end

  assign inst        = inst_q;
  assign inst_valid  = inst_valid_q;
  assign fetch_fault = fetch_fault_q;
  assign ld_done     = (state_q == ST_RUN);

endmodule
